ro_sampler_ctrl: RTL and testbench

Controller for a bank of free-running ring oscillator cells in the TRNG entropy source. It enables the oscillators, waits a warm-up period, and samples their asynchronous outputs through synchronizers. The sampled outputs are XOR-reduced into one raw bit per sample, and the bits are packed into words that are delivered over a valid/ready handshake. It sits between the RO cell array and the post-processing/readout logic, and also flags a stuck entropy source.

---
 rtl/ro_sampler_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ro_sampler_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_sampler_ctrl.sv
// Ring-oscillator sampling controller: enables the RO bank, warms it up, samples the
// synchronized outputs, packs XOR-reduced bits into words and flags a stuck source.
module ro_sampler_ctrl #(
  parameter int NUM_RO        = 8,
  parameter int WARMUP_CYCLES = 64,
  parameter int SAMPLE_DIV    = 4,
  parameter int WORD_W        = 32,
  parameter int STUCK_LIMIT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_en,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy,
  output logic              stuck_err
);

  localparam int WCW = $clog2(WARMUP_CYCLES);
  localparam int DCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BCW = $clog2(WORD_W);
  localparam int RCW = $clog2(STUCK_LIMIT + 1);

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
  localparam logic [WCW-1:0] WARM_ONE  = WCW'(1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(SAMPLE_DIV - 1);
  localparam logic [DCW-1:0] DIV_ONE   = DCW'(1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
  localparam logic [RCW-1:0] RUN_MAX   = RCW'(STUCK_LIMIT);
  localparam logic [RCW-1:0] RUN_ONE   = RCW'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [NUM_RO-1:0] sync1;
  logic [NUM_RO-1:0] sync2;
  logic [WCW-1:0]    warm_cnt;
  logic [DCW-1:0]    div_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shift_word;
  logic [RCW-1:0]    run_cnt;
  logic [RCW-1:0]    run_nxt;
  logic              prev_bit;
  logic              raw_bit;
  logic              sample_tick;
  logic              word_done;
  logic              xfer;

  assign raw_bit = ^sync2;

  // Next-state decode, sample strobes and run-length update
  always_comb begin
    state_nxt   = state;
    sample_tick = 1'b0;
    word_done   = 1'b0;
    xfer        = 1'b0;
    shift_word  = {shreg[WORD_W-2:0], raw_bit};
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_WARMUP;
        else       state_nxt = ST_IDLE;
      end
      ST_WARMUP: begin
        if (!start)                     state_nxt = ST_IDLE;
        else if (warm_cnt == WARM_LAST) state_nxt = ST_SAMPLE;
        else                            state_nxt = ST_WARMUP;
      end
      ST_SAMPLE: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end else begin
          sample_tick = (div_cnt == DIV_LAST);
          word_done   = sample_tick && (bit_cnt == BIT_LAST);
          if (word_done) state_nxt = ST_HOLD;
          else           state_nxt = ST_SAMPLE;
        end
      end
      ST_HOLD: begin
        xfer = rnd_valid && rnd_ready;
        if (xfer) state_nxt = start ? ST_SAMPLE : ST_IDLE;
        else      state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A cleared run counter means no previous bit to compare against yet
    if (run_cnt == {RCW{1'b0}})  run_nxt = RUN_ONE;
    else if (raw_bit == prev_bit) run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_ONE;
    else                          run_nxt = RUN_ONE;
  end

  // State, synchronizers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sync1     <= {NUM_RO{1'b0}};
      sync2     <= {NUM_RO{1'b0}};
      warm_cnt  <= {WCW{1'b0}};
      div_cnt   <= {DCW{1'b0}};
      bit_cnt   <= {BCW{1'b0}};
      shreg     <= {WORD_W{1'b0}};
      run_cnt   <= {RCW{1'b0}};
      prev_bit  <= 1'b0;
      ro_en     <= {NUM_RO{1'b0}};
      rnd_data  <= {WORD_W{1'b0}};
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
      stuck_err <= 1'b0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      state <= state_nxt;
      ro_en <= (state_nxt != ST_IDLE) ? {NUM_RO{1'b1}} : {NUM_RO{1'b0}};
      busy  <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          warm_cnt <= {WCW{1'b0}};
          run_cnt  <= {RCW{1'b0}};
        end
        ST_WARMUP: begin
          warm_cnt <= warm_cnt + WARM_ONE;
          div_cnt  <= {DCW{1'b0}};
          bit_cnt  <= {BCW{1'b0}};
        end
        ST_SAMPLE: begin
          if (!start) begin
            div_cnt <= {DCW{1'b0}};
            bit_cnt <= {BCW{1'b0}};
          end else begin
            div_cnt <= sample_tick ? {DCW{1'b0}} : div_cnt + DIV_ONE;
            if (sample_tick) begin
              shreg    <= shift_word;
              bit_cnt  <= word_done ? {BCW{1'b0}} : bit_cnt + BIT_ONE;
              prev_bit <= raw_bit;
              run_cnt  <= run_nxt;
              if (run_nxt == RUN_MAX) stuck_err <= 1'b1;
              if (word_done) begin
                rnd_valid <= 1'b1;
                rnd_data  <= shift_word;
              end
            end
          end
        end
        ST_HOLD: begin
          if (xfer) begin
            rnd_valid <= 1'b0;
            div_cnt   <= {DCW{1'b0}};
            bit_cnt   <= {BCW{1'b0}};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_sampler_ctrl.sv
// Directed bench for ro_sampler_ctrl: a default-parameter instance plus a small
// instance for the short hand-computed pattern word.
module tb_ro_sampler_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_start, d_ready;
  logic [7:0]  d_ro_in, d_ro_en;
  logic [31:0] d_data;
  logic        d_valid, d_busy, d_stuck;
  logic        s_start, s_ready;
  logic [1:0]  s_ro_in, s_ro_en;
  logic [7:0]  s_data;
  logic        s_valid, s_busy, s_stuck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_base = 0;
  int pat_mode = 0;

  always #5 clk = ~clk;

  ro_sampler_ctrl dut (
    .clk(clk), .rst(rst), .start(d_start), .ro_in(d_ro_in), .ro_en(d_ro_en),
    .rnd_data(d_data), .rnd_valid(d_valid), .rnd_ready(d_ready), .busy(d_busy),
    .stuck_err(d_stuck)
  );

  ro_sampler_ctrl #(.NUM_RO(2), .WARMUP_CYCLES(4), .SAMPLE_DIV(1), .WORD_W(8), .STUCK_LIMIT(16)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .ro_in(s_ro_in), .ro_en(s_ro_en),
    .rnd_data(s_data), .rnd_valid(s_valid), .rnd_ready(s_ready), .busy(s_busy),
    .stuck_err(s_stuck)
  );

  // Raw bit the default instance sees before edge c (XOR of its ro_in bits)
  function automatic logic fbit(input int c);
    logic [31:0] cv;
    cv = c;
    return (pat_mode == 1) ? 1'b0 : cv[2];
  endfunction

  // Word expected when SAMPLE is entered at edge 'entry' (sample k at entry+4k sees ro_in of edge-2)
  function automatic logic [31:0] exp_word(input int entry);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 1; k <= 32; k++) w = {w[30:0], fbit(entry + 4 * k - 2)};
    return w;
  endfunction

  task automatic drive_ro;
    logic [31:0] nc, sd;
    nc = cyc + 1;
    sd = nc - s_base;
    d_ro_in = {2'b00, nc[0], 4'b0000, fbit(cyc + 1) ^ nc[0]};
    s_ro_in = {1'b0, sd[0]};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    drive_ro();
  endtask

  task automatic test_pattern;
    int n;
    s_ready = 1'b1;
    s_start = 1'b1;
    s_base  = cyc + 1;
    tick();
    n = cyc;
    checks++; if (s_ro_en !== 2'b11) begin errors++; $display("FAIL pat_ro_en: got %b expected 11", s_ro_en); end
    repeat (11) tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL pat_valid_early: got %b expected 0 at edge %0d", s_valid, cyc - n); end
    tick();
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL pat_valid: got %b expected 1", s_valid); end
    checks++; if (s_data !== 8'hAA) begin errors++; $display("FAIL pat_data: got %h expected aa", s_data); end
    checks++; if (s_stuck !== 1'b0) begin errors++; $display("FAIL pat_stuck: got %b expected 0", s_stuck); end
    s_start = 1'b0;
    tick();
    s_ready = 1'b0;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL pat_xfer: got %b expected 0", s_valid); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL pat_idle_busy: got %b expected 0", s_busy); end
  endtask

  task automatic test_reset;
    int e0;
    rst = 1'b1;
    d_start = 1'b1;
    repeat (3) tick();
    checks++; if (d_ro_en !== 8'h00) begin errors++; $display("FAIL rst_ro_en: got %h expected 00", d_ro_en); end
    checks++; if (d_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", d_data); end
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", d_valid); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", d_busy); end
    checks++; if (d_stuck !== 1'b0) begin errors++; $display("FAIL rst_stuck: got %b expected 0", d_stuck); end
    rst = 1'b0;
    tick();
    e0 = cyc;
    checks++; if (d_ro_en !== 8'hFF) begin errors++; $display("FAIL start_ro_en: got %h expected ff", d_ro_en); end
    checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", d_busy); end
    repeat (191) tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL first_word_early: got %b expected 0", d_valid); end
    tick();
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL first_word_valid: got %b expected 1", d_valid); end
    checks++; if (d_data !== exp_word(e0 + 64)) begin errors++; $display("FAIL first_word_data: got %h expected %h", d_data, exp_word(e0 + 64)); end
  endtask

  task automatic test_backpressure;
    logic [31:0] held;
    int t;
    held = d_data;
    d_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++; if (d_valid !== 1'b1 || d_data !== held || d_ro_en !== 8'hFF) begin
        errors++; $display("FAIL bp_hold: valid %b data %h ro_en %h, expected 1 %h ff", d_valid, d_data, d_ro_en, held);
      end
    end
    d_ready = 1'b1;
    tick();
    t = cyc;
    d_ready = 1'b0;
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL bp_xfer: got %b expected 0", d_valid); end
    checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", d_busy); end
    repeat (127) tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL bp_next_early: got %b expected 0", d_valid); end
    tick();
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b expected 1", d_valid); end
    checks++; if (d_data !== exp_word(t)) begin errors++; $display("FAIL bp_next_data: got %h expected %h", d_data, exp_word(t)); end
    d_ready = 1'b1;
    d_start = 1'b0;
    tick();
    d_ready = 1'b0;
    checks++; if (d_valid !== 1'b0 || d_busy !== 1'b0 || d_ro_en !== 8'h00) begin
      errors++; $display("FAIL bp_to_idle: valid %b busy %b ro_en %h expected 0 0 00", d_valid, d_busy, d_ro_en);
    end
  endtask

  task automatic test_abort;
    int r;
    d_start = 1'b1;
    tick();
    repeat (104) tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b expected 0", d_valid); end
    d_start = 1'b0;
    tick();
    checks++; if (d_ro_en !== 8'h00) begin errors++; $display("FAIL abort_ro_en: got %h expected 00", d_ro_en); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", d_busy); end
    repeat (5) tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL abort_idle_valid: got %b expected 0", d_valid); end
    d_start = 1'b1;
    tick();
    r = cyc;
    repeat (191) tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL restart_early: got %b expected 0", d_valid); end
    tick();
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL restart_valid: got %b expected 1", d_valid); end
    checks++; if (d_data !== exp_word(r + 64)) begin errors++; $display("FAIL restart_data: got %h expected %h", d_data, exp_word(r + 64)); end
    d_ready = 1'b1;
    d_start = 1'b0;
    tick();
    d_ready = 1'b0;
  endtask

  task automatic test_stuck;
    pat_mode = 1;
    d_start = 1'b1;
    tick();
    repeat (127) tick();
    checks++; if (d_stuck !== 1'b0) begin errors++; $display("FAIL stuck_early: got %b expected 0", d_stuck); end
    tick();
    checks++; if (d_stuck !== 1'b1) begin errors++; $display("FAIL stuck_rise: got %b expected 1", d_stuck); end
    repeat (64) tick();
    checks++; if (d_valid !== 1'b1 || d_data !== 32'h0) begin errors++; $display("FAIL stuck_word: valid %b data %h expected 1 0", d_valid, d_data); end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    checks++; if (d_stuck !== 1'b1) begin errors++; $display("FAIL stuck_after_xfer: got %b expected 1", d_stuck); end
    d_start = 1'b0;
    tick();
    checks++; if (d_busy !== 1'b0 || d_stuck !== 1'b1) begin errors++; $display("FAIL stuck_idle: busy %b stuck %b expected 0 1", d_busy, d_stuck); end
    d_start = 1'b1;
    tick();
    checks++; if (d_stuck !== 1'b1) begin errors++; $display("FAIL stuck_restart: got %b expected 1", d_stuck); end
    repeat (192) tick();
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL stuck_hold_valid: got %b expected 1", d_valid); end
  endtask

  task automatic test_hold_reset;
    rst = 1'b1;
    tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL hrst_valid: got %b expected 0", d_valid); end
    checks++; if (d_data !== 32'h0) begin errors++; $display("FAIL hrst_data: got %h expected 0", d_data); end
    checks++; if (d_ro_en !== 8'h00) begin errors++; $display("FAIL hrst_ro_en: got %h expected 00", d_ro_en); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL hrst_busy: got %b expected 0", d_busy); end
    checks++; if (d_stuck !== 1'b0) begin errors++; $display("FAIL hrst_stuck: got %b expected 0", d_stuck); end
    rst = 1'b0;
    d_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    d_start = 1'b0;
    d_ready = 1'b0;
    s_start = 1'b0;
    s_ready = 1'b0;
    drive_ro();
    repeat (2) tick();
    rst = 1'b0;
    test_pattern();
    test_reset();
    test_backpressure();
    test_abort();
    test_stuck();
    test_hold_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
